mole_spawner: RTL and testbench

Round controller and pattern generator that drives the load side of the mole board register.
- Per round: issues a one-cycle load pulse with a pseudo-random, non-zero 5-bit mole pattern.
- Watches the returned board_state until the player clears it or the round times out.
- Clears the board, waits a short gap, then repeats for a fixed number of rounds and flags game over.
- Sits between the top-level start control and the mole board register; score counting stays downstream on score_trigger.

---
 rtl/mole_pkg.sv | 15 +
 rtl/mole_spawner_if.sv | 24 ++
 rtl/lfsr16.sv | 20 ++
 rtl/mole_spawner.sv | 151 +++++++++++++++
 tb/tb_mole_spawner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared constants, state encoding and pattern helper for the mole spawner.
package mole_pkg;

  localparam int unsigned NUM_HOLES = 5;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [NUM_HOLES-1:0] ZERO_SUB_PATTERN = 5'b00100;

  typedef enum logic [2:0] {IDLE, SPAWN, WAIT, GAP, DONE} state_e;

  // An all-zero draw would spawn an empty board, so it is replaced.
  function automatic logic [NUM_HOLES-1:0] spawnPattern(input logic [NUM_HOLES-1:0] raw);
    return (raw == '0) ? ZERO_SUB_PATTERN : raw;
  endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Load-side bus between the start control, the mole spawner and the mole board register.
interface mole_spawner_if;
  import mole_pkg::*;

  logic                 start;
  logic [NUM_HOLES-1:0] board_state;
  logic                 load;
  logic [NUM_HOLES-1:0] loadval;
  logic [7:0]           round_cnt;
  logic [7:0]           cleared_cnt;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, board_state,
    output load, loadval, round_cnt, cleared_cnt, busy, done
  );

  modport slave (
    output start, board_state,
    input  load, loadval, round_cnt, cleared_cnt, busy, done
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable for any pseudo-random event source.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state_o
);
  import mole_pkg::*;

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign state_o = state_q;

endmodule

// File: rtl/mole_spawner.sv
// Round controller: spawns random mole patterns, tracks clears/timeouts, ends after NUM_ROUNDS.
// Optional macro SPEEDUP_EN shortens the round timeout as the game progresses.
module mole_spawner #(
  parameter int unsigned TICKS_PER_ROUND = 50_000_000,
  parameter int unsigned GAP_TICKS       = 12_500_000,
  parameter int unsigned NUM_ROUNDS      = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic            clk,
  input logic            rst_n,
  mole_spawner_if.master bus
);
  import mole_pkg::*;

  localparam logic [31:0] LIMIT_FULL = 32'(TICKS_PER_ROUND);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_TICKS - 1);

  state_e               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic                 load_q, load_d;
  logic [NUM_HOLES-1:0] loadval_q, loadval_d;
  logic [7:0]           roundCnt_q, roundCnt_d;
  logic [7:0]           clearedCnt_q, clearedCnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 roundOver;
  logic [31:0]          limit;
  logic [15:0]          lfsr;
  logic [10:0]          unusedLfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .state_o(lfsr)
  );

  assign unusedLfsr = lfsr[15:NUM_HOLES];

`ifdef SPEEDUP_EN
  localparam logic [31:0] LIMIT_STEP  = 32'(TICKS_PER_ROUND / 16);
  localparam logic [31:0] LIMIT_FLOOR = 32'(TICKS_PER_ROUND / 4);

  logic [31:0] limit_q, limit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) limit_q <= LIMIT_FULL;
    else        limit_q <= limit_d;
  end

  assign limit = limit_q;
`else
  assign limit = LIMIT_FULL;
`endif

  // Outputs are derived from the next state so each one leaves a flop.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    load_d       = 1'b0;
    loadval_d    = loadval_q;
    roundCnt_d   = roundCnt_q;
    clearedCnt_d = clearedCnt_q;
    roundOver    = 1'b0;
`ifdef SPEEDUP_EN
    limit_d      = limit_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d      = SPAWN;
          load_d       = 1'b1;
          loadval_d    = spawnPattern(lfsr[NUM_HOLES-1:0]);
          roundCnt_d   = 8'd1;
          clearedCnt_d = 8'd0;
`ifdef SPEEDUP_EN
          limit_d      = LIMIT_FULL;
`endif
        end
      end
      SPAWN: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_q + 32'd1;
        // The board register lags the load by a cycle, so its first WAIT value is stale.
        if (timer_q != '0 && bus.board_state == '0) begin
          roundOver = 1'b1;
          if (clearedCnt_q != 8'hFF) clearedCnt_d = clearedCnt_q + 8'd1;
        end else if (timer_q == limit - 32'd1) begin
          roundOver = 1'b1;
        end
        if (roundOver) begin
          state_d   = GAP;
          timer_d   = '0;
          load_d    = 1'b1;
          loadval_d = '0;
`ifdef SPEEDUP_EN
          limit_d   = (limit_q - LIMIT_STEP < LIMIT_FLOOR) ? LIMIT_FLOOR : limit_q - LIMIT_STEP;
`endif
        end
      end
      GAP: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == GAP_LAST) begin
          if (roundCnt_q < 8'(NUM_ROUNDS)) begin
            state_d    = SPAWN;
            load_d     = 1'b1;
            loadval_d  = spawnPattern(lfsr[NUM_HOLES-1:0]);
            roundCnt_d = roundCnt_q + 8'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SPAWN) || (state_d == WAIT) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      load_q       <= 1'b0;
      loadval_q    <= '0;
      roundCnt_q   <= '0;
      clearedCnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      load_q       <= load_d;
      loadval_q    <= loadval_d;
      roundCnt_q   <= roundCnt_d;
      clearedCnt_q <= clearedCnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.load        = load_q;
  assign bus.loadval     = loadval_q;
  assign bus.round_cnt   = roundCnt_q;
  assign bus.cleared_cnt = clearedCnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed, table-driven bench for mole_spawner with short round/gap/game parameters.
module tb_mole_spawner;

  localparam int unsigned TICKS  = 8;
  localparam int unsigned GAPT   = 2;
  localparam int unsigned ROUNDS = 3;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int V_ZERO = 0;
  localparam int V_NEW  = 1;
  localparam int V_HOLD = 2;

  typedef struct {
    logic       start;
    logic [4:0] board;
    logic       expLoad;
    int         valSel;
    logic [7:0] expRc;
    logic [7:0] expCc;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mLfsr, mPrev;
  logic [4:0]  lastPat, firstPat, expPat;
  logic [7:0]  prevRc;
  int          spawns, cyc;
  vec_t        vecs[$];

  mole_spawner_if bus();

  mole_spawner #(
    .TICKS_PER_ROUND(TICKS),
    .GAP_TICKS      (GAPT),
    .NUM_ROUNDS     (ROUNDS),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [4:0] pat(input logic [15:0] s);
    return (s[4:0] == 5'd0) ? 5'b00100 : s[4:0];
  endfunction

  // Reference LFSR; mPrev is the value the DUT saw just before the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLfsr <= SEED;
      mPrev <= SEED;
    end else begin
      mPrev <= mLfsr;
      mLfsr <= lfsrNext(mLfsr);
    end
  end

  task automatic applyStimulus(input logic start, input logic [4:0] board);
    bus.start       = start;
    bus.board_state = board;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expLoad, input logic [4:0] expVal,
                             input logic [7:0] expRc, input logic [7:0] expCc,
                             input logic expBusy, input logic expDone);
    logic [23:0] got, exp;
    got = {bus.load, bus.loadval, bus.round_cnt, bus.cleared_cnt, bus.busy, bus.done};
    exp = {expLoad, expVal, expRc, expCc, expBusy, expDone};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got load=%0b loadval=%b rc=%0d cc=%0d busy=%0b done=%0b, expected load=%0b loadval=%b rc=%0d cc=%0d busy=%0b done=%0b",
               name, bus.load, bus.loadval, bus.round_cnt, bus.cleared_cnt, bus.busy, bus.done,
               expLoad, expVal, expRc, expCc, expBusy, expDone);
    end
  endtask

  task automatic checkBits(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic addVec(input logic s, input logic [4:0] b, input logic l, input int v,
                        input logic [7:0] rc, input logic [7:0] cc, input logic bz, input logic dn);
    vec_t t;
    t = '{s, b, l, v, rc, cc, bz, dn};
    vecs.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Three rounds: cleared on 3rd WAIT cycle, full timeout, cleared on 2nd WAIT cycle.
    addVec(1, 5'h1F, 1, V_NEW,  1, 0, 1, 0);
    addVec(0, 5'h1F, 0, V_HOLD, 1, 0, 1, 0);
    addVec(1, 5'h00, 0, V_HOLD, 1, 0, 1, 0);
    addVec(0, 5'h1F, 0, V_HOLD, 1, 0, 1, 0);
    addVec(0, 5'h00, 1, V_ZERO, 1, 1, 1, 0);
    addVec(0, 5'h1F, 0, V_ZERO, 1, 1, 1, 0);
    addVec(0, 5'h00, 1, V_NEW,  2, 1, 1, 0);
    addVec(0, 5'h00, 0, V_HOLD, 2, 1, 1, 0);
    for (int i = 0; i < 7; i++) addVec(0, 5'b10001, 0, V_HOLD, 2, 1, 1, 0);
    addVec(0, 5'b10001, 1, V_ZERO, 2, 1, 1, 0);
    addVec(0, 5'b10001, 0, V_ZERO, 2, 1, 1, 0);
    addVec(0, 5'b10001, 1, V_NEW,  3, 1, 1, 0);
    addVec(0, 5'b10001, 0, V_HOLD, 3, 1, 1, 0);
    addVec(0, 5'h00, 0, V_HOLD, 3, 1, 1, 0);
    addVec(0, 5'h00, 1, V_ZERO, 3, 2, 1, 0);
    addVec(0, 5'h00, 0, V_ZERO, 3, 2, 1, 0);
    addVec(0, 5'h00, 0, V_ZERO, 3, 2, 0, 1);
    addVec(0, 5'h00, 0, V_ZERO, 3, 2, 0, 1);

    applyStimulus(0, 5'h00);
    lastPat  = 5'd0;
    firstPat = 5'd0;
    #2;
    checkOutput("reset_state", 0, 5'd0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      checkOutput("idle_no_start", 0, 5'd0, 0, 0, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].board);
      step();
      if (vecs[i].valSel == V_NEW) lastPat = pat(mPrev);
      else if (vecs[i].valSel == V_ZERO) lastPat = 5'd0;
      if (i == 0) firstPat = lastPat;
      checkOutput($sformatf("vec%0d", i), vecs[i].expLoad, lastPat, vecs[i].expRc,
                  vecs[i].expCc, vecs[i].expBusy, vecs[i].expDone);
    end

    for (int i = 0; i < 50; i++) begin
      step();
      checkOutput("done_quiet", 0, 5'd0, 3, 2, 0, 1);
    end

    applyStimulus(1, 5'h1F);
    step();
    expPat = pat(mPrev);
    checkOutput("restart_spawn", 1, expPat, 1, 0, 1, 0);
    applyStimulus(0, 5'h1F);
    step();
    checkOutput("restart_wait", 0, expPat, 1, 0, 1, 0);
    step();
    #3 rst_n = 1'b0;
    #1 checkOutput("reset_mid_wait", 0, 5'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    applyStimulus(1, 5'h1F);
    step();
    checkOutput("reset_replay_spawn", 1, firstPat, 1, 0, 1, 0);

    // Random player behaviour; every spawn must match the model and never be empty.
    prevRc = bus.round_cnt;
    spawns = 0;
    cyc    = 0;
    while (spawns < 1000 && cyc < 30000) begin
      applyStimulus(bus.done ? 1'b1 : ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      step();
      cyc++;
      if (bus.load) begin
        if (bus.round_cnt != prevRc) begin
          spawns++;
          checkBits("rand_spawn_pattern", {3'b000, bus.loadval}, {3'b000, pat(mPrev)});
          checks++;
          if (bus.loadval == 5'd0) begin
            failures++;
            $display("[TB] FAIL rand_spawn_nonzero: got loadval=%b, expected non-zero", bus.loadval);
          end
        end else begin
          checkBits("rand_clear_pattern", {3'b000, bus.loadval}, 8'd0);
        end
      end
      prevRc = bus.round_cnt;
    end
    checkBits("rand_spawn_count_reached", 8'(spawns >= 1000), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
